// File: rtl/fp32_add_hs.sv
// Multi-cycle binary32 adder with load/ready/ack handshake: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
// Optional macro FADD_RNE_EN selects round-to-nearest-even; otherwise results are truncated toward zero.
module fp32_add_hs (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] Number1,
   input  logic [31:0] Number2,
   input  logic        result_ack,
   output logic [31:0] Result,
   output logic        result_ready
);

   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
   state_t state_reg, state_next;

   logic [1:0][31:0] op_reg;
   logic [1:0]       sign_u_reg;
   logic [1:0][7:0]  exp_u_reg;
   logic [1:0][23:0] sig_u_reg;
   logic             special_reg;
   logic [31:0]      special_val_reg;
   logic [26:0]      big_reg, small_reg;
   logic [9:0]       exp_reg;
   logic             sign_reg, sub_reg, zero_sign_reg;
   logic [27:0]      sum_reg;
   logic [26:0]      mant_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (load) state_next = UNPACK;
         UNPACK:  state_next = ALIGN;
         ALIGN:   state_next = ADD;
         ADD:     state_next = NORM;
         NORM:    state_next = ROUND;
         ROUND:   state_next = DONE;
         DONE:    if (result_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Per-operand field split; subnormals get hidden bit 0 and effective exponent 1.
   logic [1:0]       un_sign, un_inf, un_nan;
   logic [1:0][7:0]  un_exp;
   logic [1:0][23:0] un_sig;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
         logic [7:0]  field;
         logic [22:0] frac;
         assign field       = op_reg[gi][30:23];
         assign frac        = op_reg[gi][22:0];
         assign un_sign[gi] = op_reg[gi][31];
         assign un_exp[gi]  = (field == 8'd0) ? 8'd1 : field;
         assign un_sig[gi]  = {field != 8'd0, frac};
         assign un_inf[gi]  = (field == 8'hFF) && (frac == 23'd0);
         assign un_nan[gi]  = (field == 8'hFF) && (frac != 23'd0);
      end
   endgenerate

   logic        special_next;
   logic [31:0] special_val_next;

   always_comb begin
      special_next     = 1'b1;
      special_val_next = QNAN;
      if ((|un_nan) || ((&un_inf) && (un_sign[0] != un_sign[1])))
         special_val_next = QNAN;
      else if (un_inf[0])
         special_val_next = op_reg[0];
      else if (un_inf[1])
         special_val_next = op_reg[1];
      else
         special_next = 1'b0;
   end

   // Alignment: larger magnitude becomes the big operand; smaller is shifted with sticky collection.
   logic        a_bigger;
   logic [7:0]  big_exp, small_exp, exp_diff;
   logic [23:0] big_sig, small_sig;
   logic        big_sign;
   logic [26:0] small_ext, small_aligned, shift_mask;

   always_comb begin
      a_bigger  = {exp_u_reg[0], sig_u_reg[0]} >= {exp_u_reg[1], sig_u_reg[1]};
      big_exp   = a_bigger ? exp_u_reg[0] : exp_u_reg[1];
      small_exp = a_bigger ? exp_u_reg[1] : exp_u_reg[0];
      big_sig   = a_bigger ? sig_u_reg[0] : sig_u_reg[1];
      small_sig = a_bigger ? sig_u_reg[1] : sig_u_reg[0];
      big_sign  = a_bigger ? sign_u_reg[0] : sign_u_reg[1];
      exp_diff  = big_exp - small_exp;
      small_ext = {small_sig, 3'b000};
      shift_mask = 27'd0;
      if (exp_diff >= 8'd27) begin
         small_aligned = {26'd0, |small_sig};
      end else begin
         shift_mask    = (27'd1 << exp_diff) - 27'd1;
         small_aligned = (small_ext >> exp_diff) | {26'd0, |(small_ext & shift_mask)};
      end
   end

   // Leading-zero count over the 27-bit sum, then a shift bounded so the exponent stays at least 1.
   logic [4:0]  lz, shamt;
   logic [9:0]  limit;
   logic [26:0] norm_mant;
   logic [9:0]  norm_exp;

   always_comb begin
      lz = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (sum_reg[i]) lz = 5'(26 - i);
      end
      limit     = exp_reg - 10'd1;
      shamt     = ({5'd0, lz} > limit) ? limit[4:0] : lz;
      norm_mant = sum_reg[26:0];
      norm_exp  = exp_reg;
      if (sum_reg[27]) begin
         norm_mant = {sum_reg[27:2], sum_reg[1] | sum_reg[0]};
         norm_exp  = exp_reg + 10'd1;
      end else begin
         norm_mant = sum_reg[26:0] << shamt;
         norm_exp  = exp_reg - {5'd0, shamt};
      end
   end

   logic [23:0] round_sig;
   logic [9:0]  round_exp;
   logic [31:0] packed_result;

`ifdef FADD_RNE_EN
   logic        round_up;
   logic [24:0] round_sum;
   always_comb begin
      round_up  = mant_reg[2] & (mant_reg[1] | mant_reg[0] | mant_reg[3]);
      round_sum = {1'b0, mant_reg[26:3]} + {24'd0, round_up};
      if (round_sum[24]) begin
         round_sig = round_sum[24:1];
         round_exp = exp_reg + 10'd1;
      end else begin
         round_sig = round_sum[23:0];
         round_exp = exp_reg;
      end
   end
`else
   always_comb begin
      round_sig = mant_reg[26:3];
      round_exp = exp_reg;
   end
`endif

   // A zero mantissa after normalisation means the significands cancelled exactly (or both were zero).
   always_comb begin
      if (special_reg)
         packed_result = special_val_reg;
      else if (mant_reg == 27'd0)
         packed_result = {zero_sign_reg, 31'd0};
      else if (round_exp >= 10'd255)
         packed_result = {sign_reg, 8'hFF, 23'd0};
      else
         packed_result = {sign_reg, round_sig[23] ? round_exp[7:0] : 8'h00, round_sig[22:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_reg          <= '0;
         sign_u_reg      <= '0;
         exp_u_reg       <= '0;
         sig_u_reg       <= '0;
         special_reg     <= 1'b0;
         special_val_reg <= 32'd0;
         big_reg         <= 27'd0;
         small_reg       <= 27'd0;
         exp_reg         <= 10'd0;
         sign_reg        <= 1'b0;
         sub_reg         <= 1'b0;
         zero_sign_reg   <= 1'b0;
         sum_reg         <= 28'd0;
         mant_reg        <= 27'd0;
      end else begin
         case (state_reg)
            IDLE: if (load) begin
               op_reg[0] <= Number1;
               op_reg[1] <= Number2;
            end
            UNPACK: begin
               sign_u_reg      <= un_sign;
               exp_u_reg       <= un_exp;
               sig_u_reg       <= un_sig;
               special_reg     <= special_next;
               special_val_reg <= special_val_next;
            end
            ALIGN: begin
               big_reg       <= {big_sig, 3'b000};
               small_reg     <= small_aligned;
               exp_reg       <= {2'b00, big_exp};
               sign_reg      <= big_sign;
               sub_reg       <= sign_u_reg[0] ^ sign_u_reg[1];
               zero_sign_reg <= sign_u_reg[0] & sign_u_reg[1];
            end
            ADD: begin
               sum_reg <= sub_reg ? ({1'b0, big_reg} - {1'b0, small_reg})
                                  : ({1'b0, big_reg} + {1'b0, small_reg});
            end
            NORM: begin
               mant_reg <= norm_mant;
               exp_reg  <= norm_exp;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Result       <= 32'd0;
         result_ready <= 1'b0;
      end else if (state_reg == ROUND) begin
         Result       <= packed_result;
         result_ready <= 1'b1;
      end else if ((state_reg == DONE) && result_ack) begin
         result_ready <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp32_add_hs.sv
// Directed-vector bench for fp32_add_hs: driver pushes expected sums, a monitor pops and compares on result_ready.
module tb_fp32_add_hs;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [31:0] Number1 = 32'd0;
   logic [31:0] Number2 = 32'd0;
   logic        result_ack = 1'b0;
   logic [31:0] Result;
   logic        result_ready;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] last_result = 32'd0;
   bit          seen = 1'b0;

   fp32_add_hs dut (
      .clk(clk), .reset(reset), .load(load),
      .Number1(Number1), .Number2(Number2),
      .result_ack(result_ack), .Result(Result), .result_ready(result_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Monitor: one comparison per presented result.
   always @(negedge clk) begin
      if (result_ready && !seen) begin
         seen = 1'b1;
         if (exp_q.size() == 0) begin
            check("unexpected_result", Result, 32'hxxxxxxxx);
         end else begin
            automatic logic [31:0] e = exp_q.pop_front();
            automatic string nm = name_q.pop_front();
            $display("txn %s: Result=%h expected=%h", nm, Result, e);
            check(nm, Result, e);
         end
      end
      if (!result_ready) seen = 1'b0;
   end

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!result_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_latency"}, 32'(n), 32'd5);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input string nm);
      @(negedge clk);
      Number1 = a; Number2 = b; load = 1'b1;
      exp_q.push_back(e); name_q.push_back(nm);
      @(posedge clk); #1 load = 1'b0;
      wait_ready(nm);
   endtask

   task automatic ack_and_check(input logic [31:0] e, input string nm);
      @(negedge clk); result_ack = 1'b1;
      @(posedge clk); #1 result_ack = 1'b0;
      check({nm, "_ready_cleared"}, {31'd0, result_ready}, 32'd0);
      check({nm, "_hold_after_ack"}, Result, e);
      last_result = e;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input string nm);
      issue(a, b, e, nm);
      ack_and_check(e, nm);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", Result, 32'd0);
      check("reset_ready", {31'd0, result_ready}, 32'd0);
      @(negedge clk); reset = 1'b0;

      run_op(32'h4144CCCD, 32'h4165851F, 32'h41D528F6, "add_12p3_14p345");
      run_op(32'hB1B00000, 32'hB8200000, 32'hB8200580, "add_negatives");

      // Operands present but no load: nothing must start.
      @(negedge clk); Number1 = 32'h3F800000; Number2 = 32'h40000000;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("idle_ready_low", {31'd0, result_ready}, 32'd0);
      end
      check("idle_result_kept", Result, last_result);

`ifdef FADD_RNE_EN
      run_op(32'h65B1C000, 32'h59A02000, 32'h65B1C001, "round_far_operand");
`else
      run_op(32'h65B1C000, 32'h59A02000, 32'h65B1C000, "round_far_operand");
`endif

      // Load and operand changes while DONE must not disturb the held result.
      issue(32'h3FC00000, 32'hBF800000, 32'h3F000000, "sub_norm_shift");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); Number1 = 32'h4144CCCD; Number2 = 32'h4165851F; load = 1'b1;
         @(posedge clk); #1;
         check("done_ready_held", {31'd0, result_ready}, 32'd1);
         check("done_result_held", Result, 32'h3F000000);
      end
      // Ack with load high: only the ack acts; the load is taken on the next edge in IDLE.
      @(negedge clk); result_ack = 1'b1;
      @(posedge clk); #1 result_ack = 1'b0;
      check("ack_with_load_ready", {31'd0, result_ready}, 32'd0);
      exp_q.push_back(32'h41D528F6); name_q.push_back("load_after_ack");
      @(posedge clk); #1 load = 1'b0;
      wait_ready("load_after_ack");
      ack_and_check(32'h41D528F6, "load_after_ack");

      // Reset while in ALIGN: immediate clear, and no result afterwards.
      @(negedge clk); Number1 = 32'h3F800000; Number2 = 32'h3F800000; load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      #1;
      check("abort_result", Result, 32'd0);
      check("abort_ready", {31'd0, result_ready}, 32'd0);
      @(negedge clk); reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("abort_no_result", {31'd0, result_ready}, 32'd0);

      run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_operand");
      run_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
      run_op(32'h7F800000, 32'h3F800000, 32'h7F800000, "inf_plus_finite");
      run_op(32'h3F800000, 32'hBF800000, 32'h00000000, "exact_cancel");
      run_op(32'h80000000, 32'h80000000, 32'h80000000, "neg_zero_sum");
      run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow_inf");
      run_op(32'h00000001, 32'h00000001, 32'h00000002, "subnormal_sum");
      run_op(32'h00400000, 32'h00400000, 32'h00800000, "subnormal_to_normal");
      run_op(32'h3F800000, 32'hBFC00000, 32'hBF000000, "swap_neg_result");

      repeat (2) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
